// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester/UART byte channels and grant status of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [1:0] grant;

  // master: the byte sources plus the UART side; slave: the arbiter itself
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_ready,
    input  req0_ready, req1_ready, tx_valid, tx_data, grant
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_ready,
    output req0_ready, req1_ready, tx_valid, tx_data, grant
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Line-granular round-robin arbiter sharing one UART TX stream.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter logic [7:0]  EOL_BYTE     = 8'h0A,
  parameter int unsigned LOCK_TIMEOUT = 1000
) (
  input wire logic         clk,
  input wire logic         reset,
  uart_tx_arbiter_if.slave bus
);
  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_OWN0    = 2'd1;
  localparam logic [1:0]  c_OWN1    = 2'd2;
  localparam logic [15:0] c_TIMEOUT = 16'(LOCK_TIMEOUT);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_last;
  logic        w_last_nxt;
  logic [15:0] r_idle_cnt;
  logic [15:0] w_idle_cnt_nxt;
  logic [15:0] w_cnt_inc;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;

  logic        w_own0;
  logic        w_own1;
  logic        w_slot_free;
  logic        w_owner_valid;
  logic [7:0]  w_owner_data;
  logic        w_accept;

  assign w_own0      = (r_state == c_OWN0);
  assign w_own1      = (r_state == c_OWN1);
  // Ready looks only at the state and the output stage, never at valid.
  assign w_slot_free = !r_tx_valid || bus.tx_ready;

  assign w_owner_valid = (w_own0 && bus.req0_valid) || (w_own1 && bus.req1_valid);
  assign w_owner_data  = w_own1 ? bus.req1_data : bus.req0_data;
  assign w_accept      = w_owner_valid && w_slot_free;
  assign w_cnt_inc     = (r_idle_cnt == 16'hFFFF) ? r_idle_cnt : r_idle_cnt + 16'd1;

  assign bus.req0_ready = w_own0 && w_slot_free;
  assign bus.req1_ready = w_own1 && w_slot_free;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.grant      = {w_own1, w_own0};

  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_idle_cnt_nxt = r_idle_cnt;
    case (r_state)
      c_IDLE: begin
        w_idle_cnt_nxt = 16'd0;
        // On a tie the requester that was not granted last time wins.
        if (bus.req0_valid && (!bus.req1_valid || r_last)) begin
          w_state_nxt = c_OWN0;
          w_last_nxt  = 1'b0;
        end else if (bus.req1_valid) begin
          w_state_nxt = c_OWN1;
          w_last_nxt  = 1'b1;
        end
      end
      c_OWN0, c_OWN1: begin
        if (w_accept) begin
          w_idle_cnt_nxt = 16'd0;
          if (w_owner_data == EOL_BYTE) begin
            w_state_nxt = c_IDLE;
          end
        end else if (!w_owner_valid) begin
          // A stall (valid high, UART busy) leaves the counter untouched.
          if (w_cnt_inc >= c_TIMEOUT) begin
            w_state_nxt    = c_IDLE;
            w_idle_cnt_nxt = 16'd0;
          end else begin
            w_idle_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt    = c_IDLE;
        w_idle_cnt_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_last     <= 1'b1;
      r_idle_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  // One-entry output stage; a release to IDLE lets a held byte drain normally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_owner_data;
    end else if (r_tx_valid && bus.tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire
